// File: rtl/debug_pkg.sv
// Shared constants, state encodings and helpers for the host debug sequencer.
package debug_pkg;

    // Host command bytes and single-byte replies
    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    // Width of the frame handed to the byte transmitter (pc + cycle count)
    localparam int FRAME_W = 64;

    typedef enum logic [2:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, TX_REQ, TX_WAIT
    } state_t;

    typedef enum logic [1:0] {
        TXS_IDLE, TXS_WAIT, TXS_START, TXS_GAP
    } tx_state_t;

    // Saturating increment for the 32-bit cycle counter
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/debug_tx_seq.sv
// Serialises a latched frame onto the UART transmitter, MSB byte first,
// honouring the busy handshake, and pulses done_o once the last byte is away.
module debug_tx_seq
    import debug_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [3:0]         count_i,
    input  logic               tx_busy_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    output logic               done_o
);

    tx_state_t          st_q;
    logic [FRAME_W-1:0] frame_q;
    logic [3:0]         left_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q;
    logic               done_q;

    // Byte handshake: wait idle -> one-cycle start -> one gap cycle -> repeat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q       <= TXS_IDLE;
            frame_q    <= '0;
            left_q     <= 4'd0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                TXS_IDLE: begin
                    if (load_i) begin
                        frame_q <= frame_i;
                        left_q  <= count_i;
                        st_q    <= TXS_WAIT;
                    end
                end
                TXS_WAIT: begin
                    // The final wait for idle also covers the last byte
                    if (!tx_busy_i) begin
                        if (left_q == 4'd0) begin
                            done_q <= 1'b1;
                            st_q   <= TXS_IDLE;
                        end else begin
                            tx_data_q  <= frame_q[FRAME_W-1 -: 8];
                            tx_start_q <= 1'b1;
                            st_q       <= TXS_START;
                        end
                    end
                end
                TXS_START: begin
                    tx_start_q <= 1'b0;
                    frame_q    <= frame_q << 8;
                    left_q     <= left_q - 4'd1;
                    st_q       <= TXS_GAP;
                end
                TXS_GAP: begin
                    // Transmitter raises busy during this cycle
                    st_q <= TXS_WAIT;
                end
                default: begin
                    tx_start_q <= 1'b0;
                    st_q       <= TXS_IDLE;
                end
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign done_o     = done_q;

endmodule

// File: rtl/debug_unit.sv
// Host-side sequencer for the pipeline: decodes UART command bytes, loads
// instruction memory, runs or single-steps the core and reports pc/cycles.
module debug_unit
    import debug_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int RUN_MAX = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              pipe_enable,
    output logic              pipe_reset,
    input  logic              halt,
    input  logic [DATA_W-1:0] pc,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;

    state_t             state_q;
    logic [31:0]        cyc_q;
    logic [31:0]        run_cnt_q;
    logic [7:0]         words_q;
    logic [7:0]         byte_cnt_q;
    logic [7:0]         reply_q;
    logic               rpt_q;
    logic               imem_we_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic [DATA_W-1:0]  imem_wdata_q;
    logic               pipe_reset_q;
    logic               busy_q;

    logic               timeout_s;
    logic               run_go_s;
    logic               step_go_s;
    logic               tx_load_s;
    logic [FRAME_W-1:0] tx_frame_s;
    logic [3:0]         tx_count_s;
    logic               tx_done_s;

    // Enable is gated combinationally so halt/abort stop the pipeline in the same cycle
    assign timeout_s   = (RUN_MAX != 0) && (run_cnt_q == 32'(RUN_MAX));
    assign run_go_s    = (state_q == RUN) && !halt && !rx_valid && !timeout_s;
    assign step_go_s   = (state_q == STEP) && !halt;
    assign pipe_enable = run_go_s || step_go_s;

    // pc is sampled into the frame in the TX_REQ cycle, the first report cycle
    assign tx_load_s  = (state_q == TX_REQ);
    assign tx_frame_s = rpt_q ? {32'(pc), cyc_q} : {reply_q, 56'd0};
    assign tx_count_s = rpt_q ? 4'd8 : 4'd1;

    // Command decode, load assembly, run/step control and counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cyc_q        <= 32'd0;
            run_cnt_q    <= 32'd0;
            words_q      <= 8'd0;
            byte_cnt_q   <= 8'd0;
            reply_q      <= 8'd0;
            rpt_q        <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            pipe_reset_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        busy_q <= 1'b1;
                        case (rx_data)
                            CMD_LOAD: begin
                                pipe_reset_q <= 1'b1;
                                cyc_q        <= 32'd0;
                                imem_addr_q  <= '0;
                                state_q      <= LD_CNT;
                            end
                            CMD_RUN: begin
                                run_cnt_q <= 32'd0;
                                state_q   <= RUN;
                            end
                            CMD_STEP: begin
                                state_q <= STEP;
                            end
                            default: begin
                                rpt_q   <= 1'b0;
                                reply_q <= NAK;
                                state_q <= TX_REQ;
                            end
                        endcase
                    end
                end
                LD_CNT: begin
                    if (rx_valid) begin
                        words_q    <= rx_data;
                        byte_cnt_q <= 8'd0;
                        if (rx_data == 8'd0) begin
                            rpt_q        <= 1'b0;
                            reply_q      <= ACK;
                            pipe_reset_q <= 1'b0;
                            state_q      <= TX_REQ;
                        end else begin
                            state_q <= LD_BYTE;
                        end
                    end
                end
                LD_BYTE: begin
                    if (rx_valid) begin
                        imem_wdata_q <= (imem_wdata_q << 8) | DATA_W'(rx_data);
                        if (byte_cnt_q == 8'(BYTES - 1)) begin
                            byte_cnt_q <= 8'd0;
                            imem_we_q  <= 1'b1;
                            state_q    <= LD_WR;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 8'd1;
                        end
                    end
                end
                LD_WR: begin
                    imem_we_q   <= 1'b0;
                    imem_addr_q <= imem_addr_q + ADDR_W'(1);
                    words_q     <= words_q - 8'd1;
                    if (words_q == 8'd1) begin
                        rpt_q        <= 1'b0;
                        reply_q      <= ACK;
                        pipe_reset_q <= 1'b0;
                        state_q      <= TX_REQ;
                    end else begin
                        state_q <= LD_BYTE;
                    end
                end
                RUN: begin
                    // Any rx byte here is an abort and is swallowed
                    if (run_go_s) begin
                        cyc_q     <= sat_inc(cyc_q);
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end else begin
                        rpt_q   <= 1'b1;
                        state_q <= TX_REQ;
                    end
                end
                STEP: begin
                    if (step_go_s) begin
                        cyc_q <= sat_inc(cyc_q);
                    end
                    rpt_q   <= 1'b1;
                    state_q <= TX_REQ;
                end
                TX_REQ: begin
                    state_q <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done_s) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    debug_tx_seq u_tx_seq (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (tx_load_s),
        .frame_i    (tx_frame_s),
        .count_i    (tx_count_s),
        .tx_busy_i  (tx_busy),
        .tx_data_o  (tx_data),
        .tx_start_o (tx_start),
        .done_o     (tx_done_s)
    );

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign pipe_reset = pipe_reset_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_debug_unit.sv
// Randomised self-checking bench for debug_unit with a behavioural host/UART model.
module tb_debug_unit;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          pipe_enable;
    logic          pipe_reset;
    logic          halt;
    logic [DW-1:0] pc;
    logic          busy;

    always #5 Clk = ~Clk;

    debug_unit #(.DATA_W(DW), .ADDR_W(AW), .RUN_MAX(0)) dut (
        .Clk(Clk), .Reset(Reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .pipe_enable(pipe_enable), .pipe_reset(pipe_reset), .halt(halt),
        .pc(pc), .busy(busy)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    wr_t         mon_w;
    logic [7:0]  txq[$];
    int          en_cnt = 0;
    int          proto_err = 0;
    int          vec = 0;
    int          errs = 0;
    int          bcnt;
    logic [31:0] model_cyc;
    logic [31:0] wl[$];

    // UART transmitter model: busy rises the cycle after tx_start, lasts a few cycles
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            bcnt    <= $urandom_range(2, 6);
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end
    end

    // Observe writes, transmitted bytes and enabled cycles mid-cycle
    always @(negedge Clk) begin
        if (imem_we) begin
            mon_w.addr = int'(imem_addr);
            mon_w.data = imem_wdata;
            wq.push_back(mon_w);
        end
        if (tx_start) txq.push_back(tx_data);
        if (tx_start && tx_busy) proto_err++;
        if (pipe_enable) en_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge Clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge Clk); #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        vec++;
        if ({tx_data, tx_start, imem_we, imem_addr, imem_wdata, pipe_enable, pipe_reset, busy}
            !== {8'h00, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL reset_values: got busy=%b pipe_reset=%b en=%b we=%b start=%b expected busy=0 pipe_reset=1 others 0",
                     busy, pipe_reset, pipe_enable, imem_we, tx_start);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_cyc = 32'd0;
        repeat (3) @(negedge Clk);
        vec++;
        if ({busy, pipe_reset, pipe_enable} !== 3'b010) begin
            errs++;
            $display("FAIL reset_release_idle: got busy=%b pipe_reset=%b en=%b expected 0 1 0",
                     busy, pipe_reset, pipe_enable);
        end
    endtask

    task automatic test_load(input logic [31:0] words[$]);
        int         n;
        bit         ok;
        logic [7:0] bytes[$];
        n = words.size();
        wq.delete();
        txq.delete();
        bytes.push_back(8'h4C);
        bytes.push_back(8'(n));
        foreach (words[i])
            for (int b = 3; b >= 0; b--) bytes.push_back(words[i][8*b +: 8]);
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i < bytes.size() - 1) begin
                vec++;
                if (pipe_reset !== 1'b1) begin
                    errs++;
                    $display("FAIL load_pipe_reset_held: byte %0d got %b expected 1", i, pipe_reset);
                end
            end
        end
        wait_idle(ok);
        model_cyc = 32'd0;
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL load_timeout: busy stuck high, expected idle");
        end
        vec++;
        if (pipe_reset !== 1'b0) begin
            errs++;
            $display("FAIL load_pipe_reset_release: got %b expected 0", pipe_reset);
        end
        vec++;
        if (wq.size() != n) begin
            errs++;
            $display("FAIL load_write_count: got %0d expected %0d", wq.size(), n);
        end
        for (int i = 0; i < n && i < wq.size(); i++) begin
            vec++;
            if (wq[i].addr != (i % (1 << AW)) || wq[i].data !== words[i]) begin
                errs++;
                $display("FAIL load_write: #%0d got (%0d,%h) expected (%0d,%h)",
                         i, wq[i].addr, wq[i].data, i % (1 << AW), words[i]);
            end
        end
        vec++;
        if (txq.size() != 1 || txq[0] !== 8'h06) begin
            errs++;
            $display("FAIL load_ack: got %0d bytes first %h expected 1 byte 06",
                     txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
        end
    endtask

    task automatic test_run(input int k, input bit abort, input bit hent);
        logic [31:0] p;
        logic [63:0] exp;
        int          e0;
        int          bound;
        bit          ok;
        p = $urandom;
        pc = p;
        txq.delete();
        if (hent) k = 0;
        halt = hent;
        @(posedge Clk); #1;
        e0 = en_cnt;
        rx_data  = 8'h52;
        rx_valid = 1'b1;
        @(posedge Clk); #1;
        rx_valid = 1'b0;
        if (!hent) begin
            bound = 0;
            while ((en_cnt - e0) < k && bound < 5000) begin
                @(posedge Clk); #1;
                bound++;
            end
            if (abort) begin
                rx_data  = 8'($urandom);
                rx_valid = 1'b1;
                @(posedge Clk); #1;
                rx_valid = 1'b0;
            end else begin
                halt = 1'b1;
            end
        end
        wait_idle(ok);
        halt = 1'b0;
        if (64'(model_cyc) + 64'(k) > 64'hFFFF_FFFF) model_cyc = 32'hFFFF_FFFF;
        else model_cyc = model_cyc + 32'(k);
        exp = {p, model_cyc};
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL run_timeout: busy stuck high, expected idle");
        end
        vec++;
        if ((en_cnt - e0) != k) begin
            errs++;
            $display("FAIL run_enable_cycles: got %0d expected %0d", en_cnt - e0, k);
        end
        vec++;
        if (txq.size() != 8) begin
            errs++;
            $display("FAIL run_report_len: got %0d expected 8", txq.size());
        end
        for (int i = 0; i < 8 && i < txq.size(); i++) begin
            vec++;
            if (txq[i] !== exp[63-8*i -: 8]) begin
                errs++;
                $display("FAIL run_report_byte: #%0d got %h expected %h", i, txq[i], exp[63-8*i -: 8]);
            end
        end
    endtask

    task automatic test_step(input bit h);
        logic [31:0] p;
        logic [63:0] exp;
        int          e0;
        int          k;
        bit          ok;
        p = $urandom;
        pc = p;
        halt = h;
        txq.delete();
        e0 = en_cnt;
        send_byte(8'h53);
        wait_idle(ok);
        halt = 1'b0;
        k = h ? 0 : 1;
        if (model_cyc != 32'hFFFF_FFFF) model_cyc = model_cyc + 32'(k);
        exp = {p, model_cyc};
        vec++;
        if (!ok || (en_cnt - e0) != k) begin
            errs++;
            $display("FAIL step_enable_cycles: got %0d (idle=%b) expected %0d", en_cnt - e0, ok, k);
        end
        vec++;
        if (txq.size() != 8) begin
            errs++;
            $display("FAIL step_report_len: got %0d expected 8", txq.size());
        end
        for (int i = 0; i < 8 && i < txq.size(); i++) begin
            vec++;
            if (txq[i] !== exp[63-8*i -: 8]) begin
                errs++;
                $display("FAIL step_report_byte: #%0d got %h expected %h", i, txq[i], exp[63-8*i -: 8]);
            end
        end
    endtask

    task automatic test_nak(input logic [7:0] b);
        int e0;
        bit ok;
        wq.delete();
        txq.delete();
        e0 = en_cnt;
        send_byte(b);
        wait_idle(ok);
        vec++;
        if (!ok || txq.size() != 1 || txq[0] !== 8'h15) begin
            errs++;
            $display("FAIL nak_reply: cmd %h got %0d bytes first %h expected 1 byte 15",
                     b, txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
        end
        vec++;
        if (wq.size() != 0 || (en_cnt - e0) != 0) begin
            errs++;
            $display("FAIL nak_side_effect: writes %0d enables %0d expected 0 0", wq.size(), en_cnt - e0);
        end
    endtask

    task automatic test_reset_midload();
        wq.delete();
        txq.delete();
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        vec++;
        if ({busy, pipe_reset, imem_we, tx_start, pipe_enable} !== 5'b01000) begin
            errs++;
            $display("FAIL midload_reset_outputs: busy=%b pipe_reset=%b we=%b start=%b en=%b expected 0 1 0 0 0",
                     busy, pipe_reset, imem_we, tx_start, pipe_enable);
        end
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_cyc = 32'd0;
        repeat (10) @(negedge Clk);
        vec++;
        if (wq.size() != 0 || txq.size() != 0) begin
            errs++;
            $display("FAIL midload_no_write: writes %0d tx %0d expected 0 0", wq.size(), txq.size());
        end
        vec++;
        if ({busy, pipe_reset} !== 2'b01) begin
            errs++;
            $display("FAIL midload_after_reset: busy=%b pipe_reset=%b expected 0 1", busy, pipe_reset);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    wl.delete();
                    repeat ($urandom_range(0, 10)) wl.push_back($urandom);
                    test_load(wl);
                end
                1: test_run($urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
                2: test_step(1'($urandom_range(0, 1)));
                default: begin
                    b = 8'($urandom);
                    if (b == 8'h4C || b == 8'h52 || b == 8'h53) b = 8'h00;
                    test_nak(b);
                end
            endcase
        end
    endtask

    initial begin
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        halt      = 1'b0;
        pc        = '0;
        model_cyc = 32'd0;

        test_reset();

        wl.delete();
        wl.push_back(32'h0000_0001);
        wl.push_back(32'h1234_5678);
        test_load(wl);
        test_run(5, 1'b0, 1'b0);
        test_step(1'b0);
        test_step(1'b0);
        test_run(100, 1'b1, 1'b0);
        test_nak(8'h7F);
        wl.delete();
        test_load(wl);
        test_reset_midload();
        wl.delete();
        wl.push_back($urandom);
        test_load(wl);

        test_step(1'b1);
        test_run(0, 1'b0, 1'b1);
        wl.delete();
        for (int i = 0; i < 10; i++) wl.push_back($urandom);
        test_load(wl);

        test_random();

        vec++;
        if (proto_err != 0) begin
            errs++;
            $display("FAIL tx_protocol: tx_start while busy %0d times expected 0", proto_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
